// File: rtl/spi_multi_slave_select.sv
// SPI master chip-select sequencer: drives one of NUM_SS active-low selects through
// LEAD / XFER / LAG / GAP phases and flags malformed frame requests.
module spi_multi_slave_select #(
    parameter int NUM_SS   = 4,
    parameter int MAX_BITS = 32,
    parameter int DIV_W    = 12,
    parameter int LEAD_CYC = 2,
    parameter int LAG_CYC  = 1,
    parameter int GAP_CYC  = 3,
    parameter int SEL_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
    parameter int BITS_W   = $clog2(MAX_BITS + 1)
) (
    input  logic              PCLK,
    input  logic              PRESET_n,
    input  logic              mstr_i,
    input  logic              spiswai_i,
    input  logic [1:0]        spi_mode_i,
    input  logic              send_data_i,
    input  logic [SEL_W-1:0]  ss_sel_i,
    input  logic [BITS_W-1:0] frame_bits_i,
    input  logic [DIV_W-1:0]  BaudRateDivisor_i,
    output logic [NUM_SS-1:0] ss_n_o,
    output logic              tip_o,
    output logic              receive_data_o,
    output logic              busy_o,
    output logic              req_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_XFER,
        S_LAG,
        S_GAP
    } state_t;

    localparam int XLEN_W  = DIV_W + BITS_W;
    localparam int DLY_MAX = (LEAD_CYC > LAG_CYC)
                           ? ((LEAD_CYC > GAP_CYC) ? LEAD_CYC : GAP_CYC)
                           : ((LAG_CYC > GAP_CYC) ? LAG_CYC : GAP_CYC);
    localparam int DLY_W   = (DLY_MAX > 0) ? $clog2(DLY_MAX + 1) : 1;
    localparam int CNT_W   = (XLEN_W > DLY_W) ? XLEN_W : DLY_W;

    // Counters hold "cycles remaining minus one" for the phase being entered.
    localparam logic [CNT_W-1:0] LEAD_LD = (LEAD_CYC > 0) ? CNT_W'(LEAD_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] LAG_LD  = (LAG_CYC  > 0) ? CNT_W'(LAG_CYC  - 1) : '0;
    localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYC  > 0) ? CNT_W'(GAP_CYC  - 1) : '0;

    localparam state_t AFTER_LAG     = (GAP_CYC > 0) ? S_GAP : S_IDLE;
    localparam state_t AFTER_XFER    = (LAG_CYC > 0) ? S_LAG : AFTER_LAG;
    localparam logic [CNT_W-1:0] AFTER_XFER_LD = (LAG_CYC > 0) ? LAG_LD : GAP_LD;

    localparam logic [SEL_W:0]    NUM_SS_L   = (SEL_W + 1)'(NUM_SS);
    localparam logic [BITS_W-1:0] MAX_BITS_L = BITS_W'(MAX_BITS);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN_W-1:0]   r_xfer_len;
    logic [SEL_W-1:0]    r_sel;

    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic [NUM_SS-1:0]   w_ss_n_nxt;
    logic [DIV_W-1:0]    w_div_even;
    logic [XLEN_W-1:0]   w_xfer_len;
    logic                w_en;
    logic                w_req_ok;
    logic                w_accept;
    logic                w_err;
    logic                w_done;

    assign w_en = mstr_i & ~spiswai_i & ((spi_mode_i == 2'b00) | (spi_mode_i == 2'b01));

    // Odd divisors behave as the next lower even value.
    assign w_div_even = BaudRateDivisor_i & ~DIV_W'(1);
    assign w_xfer_len = XLEN_W'(w_div_even) * XLEN_W'(frame_bits_i);

    assign w_req_ok = ({1'b0, ss_sel_i} < NUM_SS_L)
                    & (frame_bits_i != '0)
                    & (frame_bits_i <= MAX_BITS_L)
                    & (w_div_even != '0);

    assign w_accept  = w_en & send_data_i & (r_state == S_IDLE) & w_req_ok;
    assign w_err     = w_en & send_data_i & ~w_accept;
    assign w_sel_nxt = w_accept ? ss_sel_i : r_sel;

    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        if (!w_en) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (LEAD_CYC > 0) begin
                            w_state_nxt = S_LEAD;
                            w_cnt_nxt   = LEAD_LD;
                        end else begin
                            w_state_nxt = S_XFER;
                            w_cnt_nxt   = CNT_W'(w_xfer_len - XLEN_W'(1));
                        end
                    end
                end
                S_LEAD: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_XFER;
                        w_cnt_nxt   = CNT_W'(r_xfer_len - XLEN_W'(1));
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_XFER: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = AFTER_XFER;
                        w_cnt_nxt   = AFTER_XFER_LD;
                        w_done      = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_LAG: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = AFTER_LAG;
                        w_cnt_nxt   = GAP_LD;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_ss_n_nxt = '1;
        if ((w_state_nxt == S_LEAD) || (w_state_nxt == S_XFER) || (w_state_nxt == S_LAG)) begin
            for (int i = 0; i < NUM_SS; i++) begin
                if (w_sel_nxt == SEL_W'(i)) begin
                    w_ss_n_nxt[i] = 1'b0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_xfer_len     <= '0;
            r_sel          <= '0;
            ss_n_o         <= '1;
            receive_data_o <= 1'b0;
            busy_o         <= 1'b0;
            req_err_o      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            if (w_accept) begin
                r_xfer_len <= w_xfer_len;
                r_sel      <= ss_sel_i;
            end
            ss_n_o         <= w_ss_n_nxt;
            receive_data_o <= w_done;
            busy_o         <= (w_state_nxt != S_IDLE);
            req_err_o      <= w_err;
        end
    end

    assign tip_o = ~(&ss_n_o);

endmodule
